// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// sha256_pkg : SHA-256 constants, state encoding and round helper functions
// Revision   : 1.0
// ============================================================================
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUNDS = 2'd1,
        ST_FINAL  = 2'd2
    } state_t;

    // Element 0 sits in the most significant word, so H0 lands in digest[255:224].
    typedef logic [0:7][31:0] hash_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam hash_t H_INIT = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic work_t round_step(input work_t v, input logic [31:0] k,
                                         input logic [31:0] w);
        logic [31:0] t1;
        logic [31:0] t2;
        work_t       r;
        t1  = v.h + big_sigma1(v.e) + ch(v.e, v.f, v.g) + k + w;
        t2  = big_sigma0(v.a) + maj(v.a, v.b, v.c);
        r.h = v.g;
        r.g = v.f;
        r.f = v.e;
        r.e = v.d + t1;
        r.d = v.c;
        r.c = v.b;
        r.b = v.a;
        r.a = t1 + t2;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// sha256_msg_schedule : 16-word sliding message window, emits Wt..Wt+R-1
// Revision            : 1.0
// ============================================================================
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               load_en,
    input  logic                               advance,
    input  logic [511:0]                       plain,
    output logic [ROUNDS_PER_CYCLE-1:0][31:0]  wt
);

    logic [31:0] win     [0:15];
    logic [31:0] win_adv [0:15];
    logic [31:0] new0;

    // win[0] always holds W[t]; the appended word is W[t+16].
    assign new0 = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];

    generate
        if (ROUNDS_PER_CYCLE == 2) begin : g_two
            logic [31:0] new1;
            assign new1 = small_sigma1(win[15]) + win[10] + small_sigma0(win[2]) + win[1];
            always_comb begin
                for (int i = 0; i < 14; i++) begin
                    win_adv[i] = win[i + 2];
                end
                win_adv[14] = new0;
                win_adv[15] = new1;
            end
        end else begin : g_one
            always_comb begin
                for (int i = 0; i < 15; i++) begin
                    win_adv[i] = win[i + 1];
                end
                win_adv[15] = new0;
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else if (load_en) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= plain[511 - 32*i -: 32];
            end
        end else if (advance) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= win_adv[i];
            end
        end
    end

    generate
        for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_wt
            assign wt[j] = win[j];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sha256_block_core.sv
`default_nettype none
// ============================================================================
// sha256_block_core : iterative single-block SHA-256 compression engine
// Revision          : 1.0
// ============================================================================
module sha256_block_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [511:0] plain,
    input  logic         load,
    output logic         empty,
    output logic [255:0] digest,
    output logic         ready
);

    localparam logic [5:0] STEP      = 6'(ROUNDS_PER_CYCLE);
    localparam logic [5:0] LAST_STEP = 6'(64 - ROUNDS_PER_CYCLE);

    state_t                             state;
    state_t                             state_next;
    logic [5:0]                         count;
    work_t                              work;
    work_t                              work_next;
    work_t                              stage [0:ROUNDS_PER_CYCLE];
    hash_t                              work_words;
    hash_t                              final_sum;
    logic [ROUNDS_PER_CYCLE-1:0][31:0]  wt;
    logic                               accept;
    logic                               advance;

    assign accept  = (state == ST_IDLE) && load;
    assign advance = (state == ST_ROUNDS);

    sha256_msg_schedule #(
        .ROUNDS_PER_CYCLE (ROUNDS_PER_CYCLE)
    ) u_sched (
        .clock   (clock),
        .reset   (reset),
        .load_en (accept),
        .advance (advance),
        .plain   (plain),
        .wt      (wt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (load) state_next = ST_ROUNDS;
            ST_ROUNDS: if (count == LAST_STEP) state_next = ST_FINAL;
            ST_FINAL:  state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Rounds performed in one clock are chained combinationally.
    assign stage[0] = work;
    generate
        for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
            assign stage[j + 1] = round_step(stage[j], K[count + 6'(j)], wt[j]);
        end
    endgenerate
    assign work_next = stage[ROUNDS_PER_CYCLE];

    assign work_words = hash_t'(work);
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            final_sum[i] = H_INIT[i] + work_words[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            work   <= '0;
            count  <= '0;
            digest <= '0;
            ready  <= 1'b0;
            empty  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        work  <= work_t'(H_INIT);
                        count <= '0;
                        ready <= 1'b0;
                        empty <= 1'b0;
                    end
                end
                ST_ROUNDS: begin
                    work  <= work_next;
                    count <= count + STEP;
                end
                ST_FINAL: begin
                    digest <= final_sum;
                    ready  <= 1'b1;
                    empty  <= 1'b1;
                end
                default: begin
                    empty <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_block_core.sv
`default_nettype none
// ============================================================================
// tb_sha256_block_core : directed scoreboard bench for 1- and 2-round builds
// Revision             : 1.0
// ============================================================================
module tb_sha256_block_core;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [255:0] DIG_ABC   =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic         clock = 1'b0;
    logic         reset;
    logic [511:0] plain1, plain2;
    logic         load1, load2;
    logic         empty1, empty2;
    logic         ready1, ready2;
    logic [255:0] digest1, digest2;

    always #5 clock = ~clock;

    sha256_block_core #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
        .clock  (clock),
        .reset  (reset),
        .plain  (plain1),
        .load   (load1),
        .empty  (empty1),
        .digest (digest1),
        .ready  (ready1)
    );

    sha256_block_core #(.ROUNDS_PER_CYCLE(2)) u_dut2 (
        .clock  (clock),
        .reset  (reset),
        .plain  (plain2),
        .load   (load2),
        .empty  (empty2),
        .digest (digest2),
        .ready  (ready2)
    );

    typedef struct {
        logic [255:0] dig;
        int           cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev1  = 1'b0;
    logic prev2  = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: each rising edge of ready must match the next expected result.
    always @(negedge clock) begin
        if (ready1 && !prev1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready1 at cycle %0d digest %h", cyc, digest1);
            end else begin
                e1 = q1.pop_front();
                check("digest1", digest1, e1.dig);
                check("latency1", 256'(cyc), 256'(e1.cyc));
                check("empty_at_ready1", 256'(empty1), 256'(1));
            end
        end
        prev1 = ready1;
    end

    always @(negedge clock) begin
        if (ready2 && !prev2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready2 at cycle %0d digest %h", cyc, digest2);
            end else begin
                e2 = q2.pop_front();
                check("digest2", digest2, e2.dig);
                check("latency2", 256'(cyc), 256'(e2.cyc));
            end
        end
        prev2 = ready2;
    end

    task automatic push1(input logic [255:0] dig, input int lat);
        exp_t x;
        x.dig = dig;
        x.cyc = cyc + 1 + lat;
        q1.push_back(x);
    endtask

    task automatic pulse1(input logic [511:0] blk);
        plain1 = blk;
        load1  = 1'b1;
        @(negedge clock);
        load1  = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (q1.size() != 0 || q2.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending expected 0", q1.size() + q2.size());
            q1.delete();
            q2.delete();
        end
    endtask

    initial begin
        logic ok;
        int   tgt;
        reset  = 1'b1;
        load1  = 1'b0;
        load2  = 1'b0;
        plain1 = '0;
        plain2 = '0;
        repeat (3) @(negedge clock);
        check("rst_empty", 256'(empty1), 256'(1));
        check("rst_ready", 256'(ready1), 256'(0));
        check("rst_digest", digest1, 256'(0));
        check("rst_ready2", 256'(ready2), 256'(0));
        reset = 1'b0;
        @(negedge clock);

        // "abc" on both builds together
        push1(DIG_ABC, 65);
        begin
            exp_t x;
            x.dig = DIG_ABC;
            x.cyc = cyc + 1 + 33;
            q2.push_back(x);
        end
        plain2 = BLK_ABC;
        load2  = 1'b1;
        pulse1(BLK_ABC);
        load2  = 1'b0;
        plain1 = {16{32'hdeadbeef}};
        plain2 = {16{32'hcafef00d}};
        check("busy_after_load", 256'(empty1), 256'(0));
        drain(200);

        ok = 1'b1;
        repeat (100) begin
            @(negedge clock);
            if (!ready1 || !empty1 || digest1 !== DIG_ABC) ok = 1'b0;
        end
        check("hold_100_idle", 256'(ok), 256'(1));

        // back-to-back: empty message after "abc"
        push1(DIG_EMPTY, 65);
        pulse1(BLK_EMPTY);
        check("b2b_ready_drop", 256'(ready1), 256'(0));
        check("b2b_digest_kept", digest1, DIG_ABC);
        repeat (30) @(negedge clock);
        check("b2b_digest_mid", digest1, DIG_ABC);
        drain(200);

        // load pulse mid-hash is ignored, plain changes ignored
        push1(DIG_ABC, 65);
        pulse1(BLK_ABC);
        repeat (9) @(negedge clock);
        pulse1(BLK_EMPTY);
        plain1 = '1;
        drain(200);
        ok = 1'b1;
        repeat (70) begin
            @(negedge clock);
            if (!ready1 || digest1 !== DIG_ABC) ok = 1'b0;
        end
        check("ignored_load_no_rerun", 256'(ok), 256'(1));

        // reset mid-hash discards the result
        pulse1(BLK_ABC);
        repeat (29) @(negedge clock);
        reset = 1'b1;
        ok = 1'b1;
        repeat (8) begin
            @(negedge clock);
            if (ready1 || !empty1 || digest1 !== 256'(0)) ok = 1'b0;
        end
        check("midhash_reset_state", 256'(ok), 256'(1));
        reset = 1'b0;
        @(negedge clock);
        push1(DIG_ABC, 65);
        pulse1(BLK_ABC);
        drain(200);

        // load held high: a new hash starts on the edge after each FINAL
        plain1 = BLK_EMPTY;
        push1(DIG_EMPTY, 65);
        push1(DIG_EMPTY, 131);
        tgt   = cyc + 132;
        load1 = 1'b1;
        while (cyc < tgt) @(negedge clock);
        load1 = 1'b0;
        drain(50);
        repeat (5) @(negedge clock);
        check("continuous_final_digest", digest1, DIG_EMPTY);
        check("continuous_final_empty", 256'(empty1), 256'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha256_block_core.md
Name: sha256_block_core

Overview:
Single-block SHA-256 compression engine, the responder behind the SHA-2 CSR wrapper.
- Accepts one pre-padded 512-bit message block on a load pulse.
- Runs the 64 compression rounds iteratively and adds the standard initial hash H0..H7.
- Presents the 256-bit digest with a level "ready" flag.
- Performs no padding and no multi-block chaining; the wrapper supplies a fully padded single block.

Parameters:
ROUNDS_PER_CYCLE, 1, compression rounds per clock; legal values 1 or 2; round phase lasts 64/ROUNDS_PER_CYCLE cycles.

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high; may be held for any number of cycles
plain  input  512  padded block, big-endian words: plain[511:480]=W0 ... plain[31:0]=W15
load  input  1  start request; sampled only when empty=1
empty  output  1  core idle and able to accept load
digest  output  256  result, digest[255:224]=H0 ... digest[31:0]=H7
ready  output  1  digest valid; level, held until next accepted load or reset

Behaviour:
- Reset (any cycle, including mid-hash): state=IDLE, empty=1, ready=0, digest=0, round counter=0, working vars a..h=0. In-flight hash is discarded and there is no partial output.
- States:
  - IDLE: empty=1, ready as last set. Edge with load=1 moves to ROUNDS. On that edge, plain is captured into the 16-word schedule window, a..h are loaded with H0 constants, counter=0, ready is cleared, empty=0.
  - ROUNDS: each edge performs ROUNDS_PER_CYCLE rounds t, t+1. Wt for t<16 comes from the window directly. For t>=16, Wt = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32. The window shifts one word per round. The counter advances by ROUNDS_PER_CYCLE. The edge completing round 63 moves to FINAL.
  - FINAL: one edge. Hi = H0_i + working var, each mod 2^32, written to digest. ready=1, empty=1, return to IDLE.
- Latency (ROUNDS_PER_CYCLE=1): load accepted at edge N gives ready=1 after edge N+65. With 2 rounds per cycle, this is edge N+33.
- load while empty=0 is ignored; no queuing, no error flag.
- load during IDLE with ready=1 starts a new hash. ready drops after the accepting edge, and digest keeps its old value until FINAL overwrites it.
- load held high continuously: a new hash is accepted on every IDLE cycle, i.e. the edge after each FINAL.
- plain is sampled only on the accepting edge; later changes have no effect.
- All arithmetic is 32-bit unsigned with carry discarded.
  - Σ0(a)=ROTR2^ROTR13^ROTR22
  - Σ1(e)=ROTR6^ROTR11^ROTR25
  - σ0=ROTR7^ROTR18^SHR3
  - σ1=ROTR17^ROTR19^SHR10
  - Ch=(e&f)^(~e&g)
  - Maj=(a&b)^(a&c)^(b&c)
- Outputs are registered; no combinational path from load or plain to any output.

Decomposition:
- Shared package sha256_pkg holds:
  - K[0..63] round constants
  - H_INIT[0..7]
  - state enum {IDLE, ROUNDS, FINAL}
  - Σ0/Σ1/σ0/σ1/Ch/Maj as functions
- One natural sub-module, sha256_msg_schedule:
  - 16×32 shift window with load/advance controls
  - emits Wt (and Wt+1 when ROUNDS_PER_CYCLE=2)
- The round datapath and FSM stay in sha256_block_core.

Test Plan:
- Block "abc" (plain=0x61626380 followed by zeros, last word 0x00000018), 1-cycle load pulse -> ready rises exactly 65 cycles after the load edge. digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; empty=1, ready stays 1 for 100 further idle cycles.
- Empty message (plain=0x80000000 followed by zeros) -> digest=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Start "abc", pulse load with the empty-message block at cycle 10 and change plain mid-hash -> the pulse is ignored and the result is still the "abc" digest at cycle 65.
- Reset asserted at round 30 for 8 cycles, then load "abc" -> during reset ready=0, digest=0, empty=1. The new hash completes 65 cycles after the load with the correct digest.
- Back-to-back: after "abc" ready, load empty-message block -> ready=0 the next cycle, digest still holds the "abc" value until completion, then shows the empty-message digest.
- ROUNDS_PER_CYCLE=2 build, "abc" -> same digest, with ready 33 cycles after the load edge.
